// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-network pooling and dense stages.
// Holds the dense-stage FSM encoding and the default geometry constants.
package bnn_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } dense_state_e;

    localparam int BNN_IMG_IN_SIZE = 14;
    localparam int BNN_NUM_CLASSES = 10;
    localparam int BNN_CHUNK       = 28;

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count over one CHUNK-bit slice.
module popcount_chunk #(
    parameter int CHUNK = 28
) (
    input  logic [CHUNK-1:0]               bits_i,
    output logic [$clog2(CHUNK+1)-1:0]     count_o
);

    localparam int PW = $clog2(CHUNK+1);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < CHUNK; i++)
            count_o = count_o + PW'(bits_i[i]);
    end

endmodule

// File: rtl/dense_popcount_core.sv
// Binary dense layer: XNOR-popcount of the pooled map against each class
// weight row, CHUNK bits per cycle, reporting the argmax class and its score.
module dense_popcount_core
    import bnn_pkg::*;
#(
    parameter int IMG_IN_SIZE = BNN_IMG_IN_SIZE,
    parameter int IN_BITS     = IMG_IN_SIZE*IMG_IN_SIZE,
    parameter int NUM_CLASSES = BNN_NUM_CLASSES,
    parameter int CHUNK       = BNN_CHUNK
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [IN_BITS-1:0]                 img_in,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_CLASSES*IN_BITS-1:0]     weights,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(NUM_CLASSES)-1:0]     class_idx,
    output logic [$clog2(IN_BITS+1)-1:0]       best_score
);

    localparam int CHUNKS = IN_BITS / CHUNK;
    localparam int CW     = $clog2(NUM_CLASSES);
    localparam int SW     = $clog2(IN_BITS+1);
    localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int IW     = $clog2(IN_BITS);
    localparam int WW     = $clog2(NUM_CLASSES*IN_BITS);
    localparam int PW     = $clog2(CHUNK+1);

    generate
        if ((IN_BITS % CHUNK) != 0 || NUM_CLASSES < 2) begin : g_bad_params
            $error("dense_popcount_core: IN_BITS must be a multiple of CHUNK and NUM_CLASSES >= 2");
        end
    endgenerate

    dense_state_e          state_q;
    logic [IN_BITS-1:0]    img_q;
    logic [CW-1:0]         c_q;
    logic [KW-1:0]         k_q;
    logic [SW-1:0]         acc_q, best_q;
    logic [CW-1:0]         cls_q;
    logic                  in_ready_q, out_valid_q;

    // One shared datapath: the active class/chunk is picked by part-select.
    logic [IW-1:0]         img_base;
    logic [WW-1:0]         w_base;
    logic [CHUNK-1:0]      xnor_bits;
    logic [PW-1:0]         pc;
    logic [SW-1:0]         score_d;
    logic                  last_k, last_c;

    assign img_base  = IW'(k_q) * IW'(CHUNK);
    assign w_base    = WW'(c_q) * WW'(IN_BITS) + WW'(img_base);
    assign xnor_bits = ~(img_q[img_base +: CHUNK] ^ weights[w_base +: CHUNK]);
    assign score_d   = acc_q + SW'(pc);
    assign last_k    = (k_q == KW'(CHUNKS-1));
    assign last_c    = (c_q == CW'(NUM_CLASSES-1));

    popcount_chunk #(.CHUNK(CHUNK)) u_popcount (
        .bits_i  (xnor_bits),
        .count_o (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            img_q       <= '0;
            c_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            best_q      <= '0;
            cls_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    img_q      <= img_in;
                    c_q        <= '0;
                    k_q        <= '0;
                    acc_q      <= '0;
                    best_q     <= '0;
                    cls_q      <= '0;
                    in_ready_q <= 1'b0;
                    state_q    <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (last_k) begin
                        k_q   <= '0;
                        acc_q <= '0;
                        // Strict compare: on a tie the earlier class stays.
                        if (c_q == '0 || score_d > best_q) begin
                            best_q <= score_d;
                            cls_q  <= c_q;
                        end
                        if (last_c) begin
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            c_q <= c_q + 1'b1;
                        end
                    end else begin
                        k_q   <= k_q + 1'b1;
                        acc_q <= score_d;
                    end
                end
                S_DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign class_idx  = cls_q;
    assign best_score = best_q;

endmodule

// File: doc/dense_popcount_core.md
DENSE_POPCOUNT_CORE -- requirements
Module: dense_popcount_core

Interface
REQ-001 Parameter IMG_IN_SIZE, default 14; side of the square binary feature map from the max-pool stage.
REQ-002 Parameter IN_BITS, default IMG_IN_SIZE*IMG_IN_SIZE (196); flattened input length.
REQ-003 Parameter NUM_CLASSES, default 10; number of output neurons.
REQ-004 Parameter CHUNK, default 28; input bits processed per cycle.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 img_in  input  IN_BITS  pooled feature map, bit index row*IMG_IN_SIZE+col.
REQ-008 in_valid  input  1  img_in valid.
REQ-009 in_ready  output  1  core idle and able to accept img_in.
REQ-010 weights  input  NUM_CLASSES*IN_BITS  binary weights; class c occupies bits [c*IN_BITS +: IN_BITS]; static during operation.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 class_idx  output  clog2(NUM_CLASSES)  winning class.
REQ-014 best_score  output  clog2(IN_BITS+1)  winning popcount.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE: on in_valid&&in_ready, capture img_in into an internal register, clear class counter c, chunk counter k and accumulator, clear best, go to ACCUM.
REQ-017 ACCUM: each cycle add popcount(~(img_reg ^ w_c) over bits [k*CHUNK +: CHUNK]) to the accumulator; k increments, wrapping to 0 after CHUNKS-1 where CHUNKS=IN_BITS/CHUNK.
REQ-018 On k==CHUNKS-1, class score = accumulator + current chunk popcount (same cycle); if c==0 or score > best, best_score<=score and class_idx<=c; accumulator clears; c increments.
REQ-019 Ties SHALL keep the lower class index (strict greater-than compare).
REQ-020 On k==CHUNKS-1 and c==NUM_CLASSES-1, state SHALL go to DONE; out_valid rises exactly NUM_CLASSES*CHUNKS cycles (70 default) after the accepting edge.
REQ-021 DONE: class_idx and best_score held stable while out_valid=1; on out_valid&&out_ready go to IDLE (in_ready=1 next cycle).
REQ-022 in_valid in ACCUM or DONE SHALL be ignored; img_in changes after acceptance SHALL not affect the result.
REQ-023 Accumulator and score width clog2(IN_BITS+1); no overflow possible (max IN_BITS).
REQ-024 Elaboration SHALL fail if IN_BITS % CHUNK != 0 or NUM_CLASSES < 2.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, in_ready=1 after release, out_valid=0, class_idx=0, best_score=0, counters, accumulator and img register to 0.
REQ-026 Reset asserted mid-ACCUM or in DONE SHALL abort the computation with no result emitted.

Structure
REQ-027 A shared package bnn_pkg SHALL hold the FSM state enum and default constants (IMG_IN_SIZE, NUM_CLASSES, CHUNK) used by the pooling and dense stages.
REQ-028 One sub-module popcount_chunk (parameter CHUNK, combinational CHUNK-bit popcount) SHALL be instantiated once.
REQ-029 Weight chunk selection SHALL be an indexed part-select on c and k; no per-class duplicated datapath.

Verification
REQ-030 img_in all 0, class 3 weights all 0, others all 1 -> out_valid at cycle 70, class_idx=3, best_score=196.
REQ-031 img_in all 1, classes 2 and 7 weights all 1, others random -> class_idx=2, best_score=196 (tie keeps lower).
REQ-032 Random img/weights, 200 iterations -> class_idx/best_score match reference model argmax of XNOR-popcount.
REQ-033 out_ready held 0 for 20 cycles in DONE -> outputs stable, in_ready=0; in_valid pulses during ACCUM ignored, result unchanged.
REQ-034 rst_n pulsed low at cycle 35 of ACCUM -> out_valid=0, in_ready=1 after release; next image computes correctly.
